regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have ports wb_valid (1), wb_rd (5), wb_data (64), inputs: pipeline writeback request; never back-pressured.
REQ-004 SHALL have ports mdu_valid (1), mdu_rd (5), mdu_data (64), inputs: multi-cycle MUL/DIV result request.
REQ-005 SHALL have port mdu_ready, output, 1 bit: MDU result can be accepted this cycle.
REQ-006 SHALL have ports iss_valid (1), iss_rd (5), inputs: an MDU op targeting iss_rd issues this cycle.
REQ-007 SHALL have ports rs1, rs2, inputs, 5 bits each: decode-stage source registers to check.
REQ-008 SHALL have outputs hazard (1), iss_waw (1), wb_stall (1): RAW hit on rs1/rs2, WAW hit on iss_rd, request to hold the pipeline writeback next cycle.
REQ-009 SHALL have outputs rf_we (1), rf_waddr (5), rf_wdata (64): drive the single register-file write port.

Function
REQ-010 SHALL hold a one-entry MDU result buffer (valid bit, 5-bit rd, 64-bit data).
REQ-011 SHALL drive mdu_ready = NOT buffer valid, combinationally from registered state.
REQ-012 SHALL load the buffer on mdu_valid AND mdu_ready AND mdu_rd != 0; on mdu_rd == 0 with mdu_ready, it SHALL accept and discard the result without occupying the buffer.
REQ-013 SHALL give pipeline writeback absolute priority: wb_valid AND wb_rd != 0 drives rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data in the same cycle (zero latency, combinational).
REQ-014 SHALL treat wb_valid with wb_rd == 0 as an idle port cycle, eligible for buffer drain.
REQ-015 SHALL drain the buffer when it is valid and the port is idle (no wb write per REQ-013): rf_we=1, rf_waddr/rf_wdata from the buffer, buffer valid cleared at the next edge.
REQ-016 SHALL drive rf_we=0 with rf_waddr=0 and rf_wdata=0 when neither source writes.
REQ-017 SHALL NOT load and drain in the same cycle; the earliest drain is the cycle after load (one-cycle MDU-to-regfile latency minimum).
REQ-018 SHALL keep a 2-bit saturating age counter: cleared when the buffer is empty or loads, incremented each cycle the buffer stays valid without draining.
REQ-019 SHALL assert wb_stall (registered) while the buffer is valid and age == 3; the pipeline then guarantees wb_valid=0 next cycle, so the drain occurs.
REQ-020 SHALL keep a 32-bit busy scoreboard; busy[0] is always 0.
REQ-021 SHALL set busy[iss_rd] at the clock edge on iss_valid AND iss_rd != 0.
REQ-022 SHALL clear busy[rf_waddr] at the clock edge of a buffer drain.
REQ-023 SHALL let set win when set and clear target the same index in one cycle.
REQ-024 SHALL drive hazard = busy[rs1] OR busy[rs2] and iss_waw = busy[iss_rd], both combinational from registered busy bits.
REQ-025 SHALL NOT let pipeline writes (REQ-013) change busy bits, even to a busy register.

Reset
REQ-026 SHALL, while rst=1, clear the buffer valid bit, age, all busy bits and wb_stall, giving mdu_ready=1, hazard=0, iss_waw=0 and rf_we=0 (absent wb_valid).
REQ-027 SHALL discard any buffered or in-flight MDU result on reset mid-operation; no regfile write results from it after rst falls.

Verification
REQ-028 SHALL cover: iss_valid, iss_rd=5, then rs1=5 -> hazard=1; later mdu_valid, rd=5, data=0x2A, no wb -> rf_we=1, waddr=5, wdata=0x2A one cycle later; busy[5]=0 after it.
REQ-029 SHALL cover: buffer valid with wb_valid, rd=7, held 3 cycles -> regfile writes go to rd 7 only; mdu_ready=0; wb_stall=1 when age=3; drain on the following wb-idle cycle.
REQ-030 SHALL cover: mdu_valid, rd=0 -> no buffer load, mdu_ready stays 1, rf_we=0.
REQ-031 SHALL cover: drain of rd 9 in the same cycle as iss_valid, iss_rd=9 -> busy[9]=1 afterwards, iss_waw=0 in that cycle is not required.
REQ-032 SHALL cover: rst asserted while the buffer holds rd 3 -> mdu_ready=1 immediately, busy all 0, no write to reg 3 after release.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the writeback, MDU result, issue and decode-check signals of the
// register-file write-port arbiter; master = pipeline side, slave = arbiter.
interface regfile_wb_arbiter_if;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [63:0] mdu_data;
    logic        mdu_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard;
    logic        iss_waw;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;

    modport master (
        output wb_valid, wb_rd, wb_data,
        output mdu_valid, mdu_rd, mdu_data,
        output iss_valid, iss_rd, rs1, rs2,
        input  mdu_ready, hazard, iss_waw, wb_stall,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  mdu_valid, mdu_rd, mdu_data,
        input  iss_valid, iss_rd, rs1, rs2,
        output mdu_ready, hazard, iss_waw, wb_stall,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares one register-file write port between the pipeline writeback and a
// one-entry MDU result buffer, and tracks in-flight MDU destinations.
module regfile_wb_arbiter (
    input  logic                   clk,
    input  logic                   rst,
    regfile_wb_arbiter_if.slave    bus
);

    logic        buf_valid_q, buf_valid_d;
    logic [4:0]  buf_rd_q, buf_rd_d;
    logic [63:0] buf_data_q, buf_data_d;
    logic [1:0]  age_q, age_d;
    logic [31:0] busy_q, busy_d;
    logic        wb_stall_q, wb_stall_d;

    logic        wb_write;
    logic        drain;
    logic        load;

    always_comb begin
        wb_write = bus.wb_valid && (bus.wb_rd != '0);
        drain    = buf_valid_q && !wb_write;
        // load requires an empty buffer, so it can never coincide with a drain
        load     = bus.mdu_valid && !buf_valid_q && (bus.mdu_rd != '0);

        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        if (wb_write) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.wb_rd;
            bus.rf_wdata = bus.wb_data;
        end else if (drain) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = buf_rd_q;
            bus.rf_wdata = buf_data_q;
        end

        buf_valid_d = buf_valid_q;
        buf_rd_d    = buf_rd_q;
        buf_data_d  = buf_data_q;
        if (load) begin
            buf_valid_d = 1'b1;
            buf_rd_d    = bus.mdu_rd;
            buf_data_d  = bus.mdu_data;
        end else if (drain) begin
            buf_valid_d = 1'b0;
        end

        if (!buf_valid_d || load) begin
            age_d = '0;
        end else if (age_q != 2'd3) begin
            age_d = age_q + 2'd1;
        end else begin
            age_d = age_q;
        end
        wb_stall_d = buf_valid_d && (age_d == 2'd3);

        // set is applied after clear so a same-index issue wins
        busy_d = busy_q;
        if (drain) begin
            busy_d[buf_rd_q] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != '0)) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_rd_q    <= '0;
            buf_data_q  <= '0;
            age_q       <= '0;
            busy_q      <= '0;
            wb_stall_q  <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_rd_q    <= buf_rd_d;
            buf_data_q  <= buf_data_d;
            age_q       <= age_d;
            busy_q      <= busy_d;
            wb_stall_q  <= wb_stall_d;
        end
    end

    assign bus.mdu_ready = !buf_valid_q;
    assign bus.hazard    = busy_q[bus.rs1] || busy_q[bus.rs2];
    assign bus.iss_waw   = busy_q[bus.iss_rd];
    assign bus.wb_stall  = wb_stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios followed by random traffic, checked against a
// transaction-level model of the buffer, its age and the busy scoreboard.
module tb_regfile_wb_arbiter;

    logic clk;
    logic rst;
    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // reference model state
    bit          m_bv;
    int          m_rd;
    logic [63:0] m_data;
    int          m_age;
    bit          m_busy [32];
    bit          m_stall;

    task automatic model_reset();
        m_bv    = 1'b0;
        m_rd    = 0;
        m_data  = '0;
        m_age   = 0;
        m_stall = 1'b0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit wbv, input int wbrd, input logic [63:0] wbd,
                          input bit mv, input int mrd, input logic [63:0] md,
                          input bit iv, input int ird, input int r1, input int r2);
        bus.wb_valid  = wbv;
        bus.wb_rd     = wbrd[4:0];
        bus.wb_data   = wbd;
        bus.mdu_valid = mv;
        bus.mdu_rd    = mrd[4:0];
        bus.mdu_data  = md;
        bus.iss_valid = iv;
        bus.iss_rd    = ird[4:0];
        bus.rs1       = r1[4:0];
        bus.rs2       = r2[4:0];
    endtask

    // Settle after the falling edge and compare every output to the model.
    task automatic settle();
        bit          wbw, drn;
        bit          e_we;
        logic [4:0]  e_addr;
        logic [63:0] e_data;
        #2;
        if (rst) model_reset();
        wbw    = bus.wb_valid && (bus.wb_rd != 0);
        drn    = !wbw && m_bv;
        e_we   = wbw || drn;
        e_addr = wbw ? bus.wb_rd : (drn ? 5'(m_rd) : 5'd0);
        e_data = wbw ? bus.wb_data : (drn ? m_data : 64'd0);
        check("mdu_ready", {63'd0, bus.mdu_ready}, {63'd0, !m_bv});
        check("hazard",    {63'd0, bus.hazard},    {63'd0, m_busy[bus.rs1] || m_busy[bus.rs2]});
        check("iss_waw",   {63'd0, bus.iss_waw},   {63'd0, m_busy[bus.iss_rd]});
        check("wb_stall",  {63'd0, bus.wb_stall},  {63'd0, m_stall});
        check("rf_we",     {63'd0, bus.rf_we},     {63'd0, e_we});
        check("rf_waddr",  {59'd0, bus.rf_waddr},  {59'd0, e_addr});
        check("rf_wdata",  bus.rf_wdata,           e_data);
    endtask

    // Advance the model across the next rising edge, then wait for the falling edge.
    task automatic advance();
        bit wbw, drn, ld, stayed;
        wbw    = bus.wb_valid && (bus.wb_rd != 0);
        drn    = !wbw && m_bv;
        ld     = bus.mdu_valid && !m_bv && (bus.mdu_rd != 0);
        stayed = m_bv && !drn;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (drn) begin
                m_busy[m_rd] = 1'b0;
                m_bv = 1'b0;
            end
            if (ld) begin
                m_bv   = 1'b1;
                m_rd   = int'(bus.mdu_rd);
                m_data = bus.mdu_data;
                m_age  = 0;
            end else if (stayed) begin
                m_age = (m_age < 3) ? m_age + 1 : 3;
            end else begin
                m_age = 0;
            end
            m_stall = m_bv && (m_age == 3);
            if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 5, 9);
        @(negedge clk);

        // reset state
        settle();
        check("rst_mdu_ready", {63'd0, bus.mdu_ready}, 64'd1);
        check("rst_hazard",    {63'd0, bus.hazard},    64'd0);
        check("rst_rf_we",     {63'd0, bus.rf_we},     64'd0);
        check("rst_wb_stall",  {63'd0, bus.wb_stall},  64'd0);
        advance();
        rst = 1'b0;

        // issue rd5, RAW on rs1, MDU result drains one cycle after load
        set_in(0, 0, 0, 0, 0, 0, 1, 5, 0, 0); settle(); advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 5, 0); settle();
        check("raw_rs1_5", {63'd0, bus.hazard}, 64'd1);
        advance();
        set_in(0, 0, 0, 1, 5, 64'h2A, 0, 0, 5, 0); settle();
        check("no_drain_on_load", {63'd0, bus.rf_we}, 64'd0);
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 5, 0); settle();
        check("drain5_we",   {63'd0, bus.rf_we},    64'd1);
        check("drain5_addr", {59'd0, bus.rf_waddr}, 64'd5);
        check("drain5_data", bus.rf_wdata,          64'h2A);
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 5, 0); settle();
        check("busy5_cleared", {63'd0, bus.hazard}, 64'd0);
        advance();

        // buffer held off by three writebacks to rd7, then stall and drain
        set_in(0, 0, 0, 0, 0, 0, 1, 20, 0, 0); settle(); advance();
        set_in(0, 0, 0, 1, 20, 64'hBEEF, 0, 0, 0, 0); settle(); advance();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 7, 64'h70 + 64'(k), 0, 0, 0, 0, 0, 20, 0); settle();
            check("hold_waddr",     {59'd0, bus.rf_waddr},  64'd7);
            check("hold_mdu_ready", {63'd0, bus.mdu_ready}, 64'd0);
            check("hold_no_stall",  {63'd0, bus.wb_stall},  64'd0);
            advance();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 20, 0); settle();
        check("age3_stall",  {63'd0, bus.wb_stall}, 64'd1);
        check("age3_waddr",  {59'd0, bus.rf_waddr}, 64'd20);
        check("age3_wdata",  bus.rf_wdata,          64'hBEEF);
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 20, 0); settle();
        check("post_drain_stall", {63'd0, bus.wb_stall},  64'd0);
        check("post_drain_ready", {63'd0, bus.mdu_ready}, 64'd1);
        advance();

        // result to x0 is accepted and discarded
        set_in(0, 0, 0, 1, 0, 64'hDEAD, 0, 0, 0, 0); settle();
        check("rd0_ready", {63'd0, bus.mdu_ready}, 64'd1);
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        check("rd0_ready_after", {63'd0, bus.mdu_ready}, 64'd1);
        check("rd0_no_write",    {63'd0, bus.rf_we},     64'd0);
        advance();

        // drain of rd9 coinciding with a new issue to rd9: set wins
        set_in(0, 0, 0, 0, 0, 0, 1, 9, 0, 0); settle(); advance();
        set_in(0, 0, 0, 1, 9, 64'h99, 0, 0, 0, 0); settle(); advance();
        set_in(0, 0, 0, 0, 0, 0, 1, 9, 0, 0); settle();
        check("drain9_addr", {59'd0, bus.rf_waddr}, 64'd9);
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0, 9, 0, 9); settle();
        check("busy9_waw",    {63'd0, bus.iss_waw}, 64'd1);
        check("busy9_hazard", {63'd0, bus.hazard},  64'd1);
        advance();

        // reset while rd3 is buffered
        set_in(0, 0, 0, 0, 0, 0, 1, 3, 0, 0); settle(); advance();
        set_in(0, 0, 0, 1, 3, 64'h33, 0, 0, 3, 0); settle(); advance();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 9, 3, 9); settle();
        check("midrst_ready",  {63'd0, bus.mdu_ready}, 64'd1);
        check("midrst_hazard", {63'd0, bus.hazard},    64'd0);
        check("midrst_waw",    {63'd0, bus.iss_waw},   64'd0);
        advance();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 3, 0); settle();
            check("postrst_no_write", {63'd0, bus.rf_we}, 64'd0);
            advance();
        end

        // random traffic; the pipeline honours wb_stall by idling writeback
        for (int i = 0; i < 1500; i++) begin
            bit wbv;
            int mrd;
            wbv = ($urandom_range(0, 9) < 6) && !m_stall;
            mrd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
            set_in(wbv, int'($urandom_range(0, 31)), {$urandom, $urandom},
                   $urandom_range(0, 2) == 0, mrd, {$urandom, $urandom},
                   $urandom_range(0, 3) == 0, int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
